// File: rtl/xg_ifetch_queue_pkg.sv
// Shared types and default sizes for the xgriscv instruction-fetch queue.
package xg_ifetch_queue_pkg;

  localparam int IFQ_DEPTH  = 4;
  localparam int ADDR_SIZE  = 32;
  localparam int INSTR_SIZE = 32;
  localparam logic [ADDR_SIZE-1:0] IFQ_RESET_PC = 32'h0000_0000;

  // Life cycle of one queue slot: issued request waits as PEND until imem
  // answers, then holds a decodable instruction as FULL until dequeued.
  typedef enum logic [1:0] {
    IFQ_FREE = 2'd0,
    IFQ_PEND = 2'd1,
    IFQ_FULL = 2'd2
  } ifq_state_t;

  // Per-slot transition. Each event only applies to a slot in the matching
  // source state, so a stray strobe can never corrupt a slot.
  function automatic ifq_state_t ifq_next_state(ifq_state_t cur,
                                                logic       alloc,
                                                logic       fill,
                                                logic       pop);
    ifq_state_t nxt;
    nxt = cur;
    if (alloc && cur == IFQ_FREE)      nxt = IFQ_PEND;
    else if (fill && cur == IFQ_PEND)  nxt = IFQ_FULL;
    else if (pop && cur == IFQ_FULL)   nxt = IFQ_FREE;
    return nxt;
  endfunction

endpackage

// File: rtl/xg_ifq_storage.sv
// Circular buffer of {state, pc, instr} slots for the fetch queue.
// Slots are allocated at tail, filled in order at fill, and retired at head.
module xg_ifq_storage
  import xg_ifetch_queue_pkg::*;
#(
  parameter int DEPTH   = IFQ_DEPTH,
  parameter int ADDR_W  = ADDR_SIZE,
  parameter int INSTR_W = INSTR_SIZE,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               alloc,
  input  logic [ADDR_W-1:0]  alloc_pc,
  input  logic               fill,
  input  logic [INSTR_W-1:0] fill_instr,
  input  logic               pop,
  output logic               head_full,
  output logic [ADDR_W-1:0]  head_pc,
  output logic [INSTR_W-1:0] head_instr,
  output logic [CNT_W-1:0]   occupied,
  output logic [CNT_W-1:0]   pending
);

  ifq_state_t         state_q [DEPTH];
  ifq_state_t         state_d [DEPTH];
  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];

  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [PTR_W-1:0] fill_q;
  logic [CNT_W-1:0] occ_q;
  logic [CNT_W-1:0] pend_q;

  logic alloc_ok;
  logic fill_ok;
  logic pop_ok;

  // Qualify the strobes so the counters stay within 0..DEPTH.
  assign alloc_ok = alloc && (occ_q != CNT_W'(DEPTH));
  assign fill_ok  = fill && (pend_q != '0);
  assign pop_ok   = pop && (state_q[head_q] == IFQ_FULL);

  assign head_full  = (state_q[head_q] == IFQ_FULL);
  assign head_pc    = pc_mem[head_q];
  assign head_instr = instr_mem[head_q];
  assign occupied   = occ_q;
  assign pending    = pend_q;

  // Next state of every slot from the pointer each event targets.
  always_comb begin
    // NOTE: every always_comb output gets a value before any condition so no path leaves it holding its old value, which would infer a latch.
    for (int i = 0; i < DEPTH; i++) begin
      state_d[i] = ifq_next_state(state_q[i],
                                  alloc_ok && (tail_q == PTR_W'(i)),
                                  fill_ok  && (fill_q == PTR_W'(i)),
                                  pop_ok   && (head_q == PTR_W'(i)));
    end
  end

  // Slot states, pointers and counters; a flush empties everything at once.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (reset || flush) begin
      for (int i = 0; i < DEPTH; i++) state_q[i] <= IFQ_FREE;
      head_q <= '0;
      tail_q <= '0;
      fill_q <= '0;
      occ_q  <= '0;
      pend_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) state_q[i] <= state_d[i];
      if (alloc_ok) tail_q <= tail_q + PTR_W'(1);
      if (fill_ok)  fill_q <= fill_q + PTR_W'(1);
      if (pop_ok)   head_q <= head_q + PTR_W'(1);
      occ_q  <= occ_q + CNT_W'(alloc_ok) - CNT_W'(pop_ok);
      pend_q <= pend_q + CNT_W'(alloc_ok) - CNT_W'(fill_ok);
    end
  end

  // Payload storage written on allocate (pc) and on fill (instruction).
  always_ff @(posedge clk) begin
    // NOTE: payload arrays have no reset; the slot state says whether a word is meaningful, and unreset arrays map onto plain RAM.
    if (alloc_ok) pc_mem[tail_q]    <= alloc_pc;
    if (fill_ok)  instr_mem[fill_q] <= fill_instr;
  end

endmodule

// File: rtl/xg_ifetch_queue.sv
// Instruction-fetch front end: sequential PC generation, imem request
// issue, in-order response capture and redirect handling with stale
// response dropping. Slot storage lives in xg_ifq_storage.
module xg_ifetch_queue
  import xg_ifetch_queue_pkg::*;
#(
  parameter int DEPTH   = IFQ_DEPTH,
  parameter int ADDR_W  = ADDR_SIZE,
  parameter int INSTR_W = INSTR_SIZE,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFQ_RESET_PC)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               req_valid,
  input  logic               req_ready,
  output logic [ADDR_W-1:0]  req_addr,
  input  logic               rsp_valid,
  input  logic [INSTR_W-1:0] rsp_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc
);

  localparam int CNT_W  = $clog2(DEPTH + 1);
  // Stale responses still in flight can exceed one queue's worth after
  // repeated redirects, so the drop counter has generous headroom.
  localparam int DROP_W = CNT_W + 3;

  logic [ADDR_W-1:0]  fetch_pc;
  logic [DROP_W-1:0]  drop;
  logic [DROP_W-1:0]  drop_d;

  logic               head_full;
  logic [ADDR_W-1:0]  head_pc;
  logic [INSTR_W-1:0] head_instr;
  logic [CNT_W-1:0]   occupied;
  logic [CNT_W-1:0]   pending;

  logic               issue;
  logic               rsp_discard;
  logic               rsp_fill;
  logic               pop;
  logic [ADDR_W-1:0]  redirect_target;

  // A response with nothing pending and nothing to drop is an imem protocol
  // error; it matches neither rsp_discard nor rsp_fill and is ignored.
  assign req_valid   = !reset && !redirect && (occupied != CNT_W'(DEPTH));
  assign req_addr    = fetch_pc;
  assign issue       = req_valid && req_ready;
  assign rsp_discard = rsp_valid && (drop != '0);
  assign rsp_fill    = rsp_valid && (drop == '0) && (pending != '0);

  // Decode flushes itself on redirect, so the head stays visible but is not
  // retired in that cycle.
  assign out_valid = !reset && head_full;
  assign out_pc    = reset ? '0 : head_pc;
  assign out_instr = reset ? '0 : head_instr;
  assign pop       = out_valid && out_ready && !redirect;

  assign redirect_target = redirect_pc & ~ADDR_W'(3);

  xg_ifq_storage #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_storage (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect),
    .alloc      (issue),
    .alloc_pc   (fetch_pc),
    .fill       (rsp_fill),
    .fill_instr (rsp_instr),
    .pop        (pop),
    .head_full  (head_full),
    .head_pc    (head_pc),
    .head_instr (head_instr),
    .occupied   (occupied),
    .pending    (pending)
  );

  // Drop count: on redirect every still-pending request becomes stale, less
  // the one answered this cycle, plus whatever was already being dropped.
  always_comb begin
    drop_d = drop;
    if (redirect) begin
      drop_d = DROP_W'(pending) - DROP_W'(rsp_fill) + drop - DROP_W'(rsp_discard);
    end else if (rsp_discard) begin
      drop_d = drop - DROP_W'(1);
    end
  end

  // Fetch PC and drop counter registers; redirect outranks sequential issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      drop     <= '0;
    end else begin
      drop <= drop_d;
      if (redirect) begin
        fetch_pc <= redirect_target;
      end else if (issue) begin
        fetch_pc <= fetch_pc + ADDR_W'(4);
      end
    end
  end

endmodule

// File: tb/tb_xg_ifetch_queue.sv
// Directed bench for xg_ifetch_queue with a variable-latency in-order imem
// model that answers each request with instr = addr >> 2.
module tb_xg_ifetch_queue;

  localparam int MAXL = 4;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        redirect;
  logic [31:0] redirect_pc;

  int errors = 0;
  int checks = 0;
  int lat    = 1;

  logic        dl_v [MAXL];
  logic [31:0] dl_a [MAXL];

  xg_ifetch_queue dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .rsp_valid   (rsp_valid),
    .rsp_instr   (rsp_instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock: capture the handshake, cross the edge, advance imem pipeline.
  task automatic tick();
    logic        fire;
    logic [31:0] a;
    fire = req_valid && req_ready;
    a    = req_addr;
    @(posedge clk);
    #1;
    for (int i = 0; i < MAXL - 1; i++) begin
      dl_v[i] = dl_v[i+1];
      dl_a[i] = dl_a[i+1];
    end
    dl_v[MAXL-1] = 1'b0;
    dl_a[MAXL-1] = '0;
    if (fire) begin
      dl_v[lat-1] = 1'b1;
      dl_a[lat-1] = a;
    end
    rsp_valid = dl_v[0];
    rsp_instr = dl_a[0] >> 2;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < MAXL; i++) begin
      dl_v[i] = 1'b0;
      dl_a[i] = '0;
    end
    rsp_valid = 1'b0;
    rsp_instr = '0;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    req_ready   = 1'b0;
    out_ready   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    clear_imem();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_ready = 1'b1; out_ready = 1'b1;
    redirect = 1'b0; redirect_pc = '0; lat = 1;
    clear_imem();
    tick();
    #1;
    checks++;
    if (req_valid !== 1'b0 || out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0)
      begin errors++; $display("FAIL reset_outputs: req_valid=%b out_valid=%b out_pc=%h out_instr=%h, want all 0", req_valid, out_valid, out_pc, out_instr); end
    reset = 1'b0;
  endtask

  task automatic test_stream();
    for (int c = 0; c < 8; c++) begin
      #1;
      checks++;
      if (req_valid !== 1'b1 || req_addr !== 32'(4 * c))
        begin errors++; $display("FAIL stream_req c=%0d: req_valid=%b req_addr=%h, want 1 %h", c, req_valid, req_addr, 32'(4 * c)); end
      checks++;
      if (c >= 2) begin
        if (out_valid !== 1'b1 || out_pc !== 32'(4 * (c - 2)) || out_instr !== 32'(c - 2))
          begin errors++; $display("FAIL stream_out c=%0d: valid=%b pc=%h instr=%h, want 1 %h %h", c, out_valid, out_pc, out_instr, 32'(4 * (c - 2)), 32'(c - 2)); end
      end else begin
        if (out_valid !== 1'b0)
          begin errors++; $display("FAIL stream_empty c=%0d: out_valid=%b, want 0", c, out_valid); end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [31:0] seen [8];
    int issued;
    do_reset();
    lat = 1; req_ready = 1'b1; out_ready = 1'b0;
    issued = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (req_valid && req_ready) begin
        if (issued < 8) seen[issued] = req_addr;
        issued++;
      end
      tick();
    end
    checks++;
    if (issued !== 4)
      begin errors++; $display("FAIL stall_issue_count: got %0d, want 4", issued); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (seen[k] !== 32'(4 * k))
        begin errors++; $display("FAIL stall_issue_addr k=%0d: got %h, want %h", k, seen[k], 32'(4 * k)); end
    end
    #1;
    checks++;
    if (req_valid !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h0)
      begin errors++; $display("FAIL stall_hold: req_valid=%b out_valid=%b out_pc=%h, want 0 1 0", req_valid, out_valid, out_pc); end
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || out_instr !== 32'(k))
        begin errors++; $display("FAIL stall_release k=%0d: valid=%b pc=%h instr=%h, want 1 %h %h", k, out_valid, out_pc, out_instr, 32'(4 * k), 32'(k)); end
      tick();
    end
  endtask

  task automatic test_redirect_pending();
    int n;
    do_reset();
    lat = 3; req_ready = 1'b1; out_ready = 1'b1;
    #1; tick();
    #1; tick();
    redirect = 1'b1; redirect_pc = 32'h103;
    #1;
    checks++;
    if (req_valid !== 1'b0)
      begin errors++; $display("FAIL redir_no_issue: req_valid=%b, want 0", req_valid); end
    tick();
    redirect = 1'b0;
    #1;
    checks++;
    if (req_valid !== 1'b1 || req_addr !== 32'h100)
      begin errors++; $display("FAIL redir_new_addr: req_valid=%b req_addr=%h, want 1 00000100", req_valid, req_addr); end
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin tick(); #1; n++; end
    checks++;
    if (n !== 4 || out_pc !== 32'h100 || out_instr !== 32'h40)
      begin errors++; $display("FAIL redir_first_out: after %0d cycles pc=%h instr=%h, want 4 00000100 00000040", n, out_pc, out_instr); end
    for (int k = 1; k < 3; k++) begin
      tick(); #1;
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(32'h100 + 4 * k) || out_instr !== 32'(32'h40 + k))
        begin errors++; $display("FAIL redir_follow k=%0d: valid=%b pc=%h instr=%h", k, out_valid, out_pc, out_instr); end
    end
  endtask

  task automatic test_redirect_with_rsp();
    int n;
    do_reset();
    lat = 1; req_ready = 1'b1; out_ready = 1'b1;
    #1; tick();
    #1; tick();
    redirect = 1'b1; redirect_pc = 32'h400;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || req_valid !== 1'b0)
      begin errors++; $display("FAIL rsp_redir_cycle: out_valid=%b out_pc=%h req_valid=%b, want 1 0 0", out_valid, out_pc, req_valid); end
    tick();
    redirect = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0)
      begin errors++; $display("FAIL rsp_redir_empty: out_valid=%b, want 0", out_valid); end
    checks++;
    if (req_valid !== 1'b1 || req_addr !== 32'h400)
      begin errors++; $display("FAIL rsp_redir_addr: req_valid=%b req_addr=%h, want 1 00000400", req_valid, req_addr); end
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin tick(); #1; n++; end
    checks++;
    if (n !== 2 || out_pc !== 32'h400 || out_instr !== 32'h100)
      begin errors++; $display("FAIL rsp_redir_first_out: after %0d cycles pc=%h instr=%h, want 2 00000400 00000100", n, out_pc, out_instr); end
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    lat = 3; req_ready = 1'b1; out_ready = 1'b1;
    #1; tick();
    #1; tick();
    redirect = 1'b1; redirect_pc = 32'h200;
    #1; tick();
    redirect_pc = 32'h300;
    #1;
    checks++;
    if (req_valid !== 1'b0)
      begin errors++; $display("FAIL b2b_no_issue: req_valid=%b, want 0", req_valid); end
    tick();
    redirect = 1'b0;
    #1;
    checks++;
    if (req_valid !== 1'b1 || req_addr !== 32'h300)
      begin errors++; $display("FAIL b2b_addr: req_valid=%b req_addr=%h, want 1 00000300", req_valid, req_addr); end
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin tick(); #1; n++; end
    checks++;
    if (n !== 4 || out_pc !== 32'h300 || out_instr !== 32'hC0)
      begin errors++; $display("FAIL b2b_first_out: after %0d cycles pc=%h instr=%h, want 4 00000300 000000c0", n, out_pc, out_instr); end
  endtask

  task automatic test_reset_midstream();
    int n;
    do_reset();
    lat = 1; req_ready = 1'b1; out_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h500;
    #1; tick();
    redirect = 1'b0;
    #1;
    checks++;
    if (req_valid !== 1'b1 || req_addr !== 32'h500)
      begin errors++; $display("FAIL mid_setup_addr: req_valid=%b req_addr=%h, want 1 00000500", req_valid, req_addr); end
    tick();
    for (int c = 0; c < 3; c++) begin #1; tick(); end
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h500 || out_instr !== 32'h140 || req_valid !== 1'b0)
      begin errors++; $display("FAIL mid_before: valid=%b pc=%h instr=%h req_valid=%b, want 1 00000500 00000140 0", out_valid, out_pc, out_instr, req_valid); end
    reset = 1'b1;
    #1;
    checks++;
    if (req_valid !== 1'b0 || out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0)
      begin errors++; $display("FAIL mid_during_reset: req_valid=%b out_valid=%b pc=%h instr=%h, want all 0", req_valid, out_valid, out_pc, out_instr); end
    tick();
    reset = 1'b0; req_ready = 1'b0;
    rsp_valid = 1'b1; rsp_instr = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (out_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h0)
      begin errors++; $display("FAIL mid_after_reset: out_valid=%b req_valid=%b req_addr=%h, want 0 1 0", out_valid, req_valid, req_addr); end
    tick();
    #1;
    checks++;
    if (out_valid !== 1'b0)
      begin errors++; $display("FAIL mid_late_rsp: out_valid=%b instr=%h, want 0", out_valid, out_instr); end
    req_ready = 1'b1; out_ready = 1'b1;
    #1;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin tick(); #1; n++; end
    checks++;
    if (n !== 2 || out_pc !== 32'h0 || out_instr !== 32'h0)
      begin errors++; $display("FAIL mid_restart: after %0d cycles pc=%h instr=%h, want 2 0 0", n, out_pc, out_instr); end
  endtask

  initial begin
    reset = 1'b1; req_ready = 1'b0; out_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    clear_imem();
    test_reset();
    test_stream();
    test_stall();
    test_redirect_pending();
    test_redirect_with_rsp();
    test_back_to_back();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
